// File: rtl/input_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_port_pkg
//  Description : Shared defaults and helpers for the buffered multi-channel
//                CPU input port (input_port_fifo / input_port_chan).
//  Contents    : DEF_WIDTH, DEF_DEPTH, DEF_CHANNELS default sizes;
//                sel_width() derives the channel-select width.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_port_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_CHANNELS = 2;

    // A single channel still needs a 1-bit select port; a select value of 1
    // then simply addresses a channel that does not exist.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage : input_port_pkg
`default_nettype wire

// File: rtl/input_port_chan.sv
`default_nettype none
// ============================================================================
//  Module      : input_port_chan
//  Description : One input channel: circular-buffer FIFO with sticky overflow.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_data          - byte to push
//                i_write         - push strobe (dropped when full, unless
//                                  a pop frees a slot in the same cycle)
//                i_read          - pop strobe (already qualified by select)
//                i_clear_ovf     - clear overflow (already qualified)
//                o_head          - entry at the read pointer
//                o_pop           - a pop is taken this cycle
//                o_empty/o_full  - occupancy flags from the registered count
//                o_overflow      - sticky: a write was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module input_port_chan
    import input_port_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_write,
    input  logic             i_read,
    input  logic             i_clear_ovf,
    output logic [WIDTH-1:0] o_head,
    output logic             o_pop,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] C_DEPTH = CNTW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    // No bypass: a read on an empty FIFO is ignored even if a write lands
    // in the same cycle. A pop on a full FIFO frees the slot the
    // simultaneous write needs, so that write is accepted.
    assign w_pop  = i_read && !w_empty;
    assign w_push = i_write && (!w_full || w_pop);
    assign w_drop = i_write && !w_push;

    // Storage carries no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            // A dropped write in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_pop      = w_pop;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule : input_port_chan
`default_nettype wire

// File: rtl/input_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : input_port_fifo
//  Description : Buffered multi-channel CPU input port. Each channel queues
//                external bytes in its own FIFO; the CPU pops one selected
//                channel at a time through a registered output.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_data          - channel c data at [c*WIDTH +: WIDTH]
//                i_write         - per-channel push strobes
//                i_sel           - channel addressed by i_read/i_clear_ovf
//                i_read          - pop strobe for channel i_sel
//                i_clear_ovf     - clear overflow flag of channel i_sel
//                o_data          - last value popped (registered)
//                o_valid         - one-cycle pulse: o_data updated
//                o_empty/o_full  - per-channel occupancy flags
//                o_overflow      - per-channel sticky drop flags
//  Revision    : 1.0 - initial release
// ============================================================================
module input_port_fifo
    import input_port_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_write,
    input  logic [SELW-1:0]           i_sel,
    input  logic                      i_read,
    input  logic                      i_clear_ovf,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid,
    output logic [CHANNELS-1:0]       o_empty,
    output logic [CHANNELS-1:0]       o_full,
    output logic [CHANNELS-1:0]       o_overflow
);

    logic [WIDTH-1:0]    w_head [CHANNELS];
    logic [CHANNELS-1:0] w_read;
    logic [CHANNELS-1:0] w_clear;
    logic [CHANNELS-1:0] w_pop;
    logic [WIDTH-1:0]    w_mux;

    logic [WIDTH-1:0]    r_data;
    logic                r_valid;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            // An out-of-range select matches no channel, so read and clear
            // are ignored without any extra range check.
            assign w_read[c]  = i_read      && (int'(i_sel) == c);
            assign w_clear[c] = i_clear_ovf && (int'(i_sel) == c);

            input_port_chan #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_data      (i_data[c*WIDTH +: WIDTH]),
                .i_write     (i_write[c]),
                .i_read      (w_read[c]),
                .i_clear_ovf (w_clear[c]),
                .o_head      (w_head[c]),
                .o_pop       (w_pop[c]),
                .o_empty     (o_empty[c]),
                .o_full      (o_full[c]),
                .o_overflow  (o_overflow[c])
            );
        end
    endgenerate

    // At most one channel pops per cycle, so a priority-free OR mux works.
    always_comb begin
        w_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_pop[c]) begin
                w_mux = w_mux | w_head[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= |w_pop;
            if (|w_pop) begin
                r_data <= w_mux;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : input_port_fifo
`default_nettype wire

// File: doc/input_port_fifo.md
# input_port_fifo

Buffered, multi-channel input port for the Simple CPU: each channel captures external bytes into its own small FIFO on a write strobe, and the CPU drains one selected channel at a time through a single registered output. It replaces the single-register input port, so input data arriving back-to-back is no longer lost before the CPU reads it. It sits between the external input pins and the CPU data bus.

## Interface
- WIDTH, 8, data width per channel
- DEPTH, 4, entries per channel FIFO; power of two, ≥2
- CHANNELS, 2, number of independent input channels; ≥1
- SELW, (CHANNELS>1 ? $clog2(CHANNELS) : 1), derived select width; not overridden
- Clk  in  1  single clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-low
- Input  in  CHANNELS*WIDTH  channel c data at [c*WIDTH +: WIDTH]
- Write  in  CHANNELS  per-channel push strobe, one entry per high cycle
- Sel  in  SELW  channel the CPU reads
- Read  in  1  pop strobe for channel Sel
- ClearOvf  in  1  clears the Overflow flag of channel Sel
- Output  out  WIDTH  last value popped (registered)
- Valid  out  1  one-cycle pulse: Output updated this cycle
- Empty  out  CHANNELS  per-channel FIFO empty
- Full  out  CHANNELS  per-channel FIFO full
- Overflow  out  CHANNELS  sticky: a write was dropped

## Operation
- Per channel: circular buffer, write pointer, read pointer, occupancy count of $clog2(DEPTH)+1 bits; pointers wrap DEPTH-1 → 0.
- Push: Write[c]=1 and not Full[c] → store Input slice at write pointer, advance pointer, count+1.
- Push while full: data dropped, no state change except Overflow[c] ← 1.
- Pop: Read=1 and not Empty[Sel] → Output ← head of channel Sel, read pointer advances, count−1, Valid=1 next cycle.
- Pop while empty: no pop, Output holds, Valid=0; no error flag.
- Simultaneous push and pop, same channel:
  - not empty, not full: both occur, count unchanged;
  - full: pop occurs and push accepted (the slot is freed in the same cycle), count stays DEPTH, no overflow;
  - empty: push accepted, pop ignored (no bypass), count becomes 1.
- Push to one channel and pop from another in the same cycle: independent.
- Sel ≥ CHANNELS: Read and ClearOvf ignored.
- ClearOvf and an overflowing write on the same channel in the same cycle: set wins, Overflow stays 1.
- Empty = (count==0), Full = (count==DEPTH), both combinational from registered count.

## Timing
- Reset (Rst low, async): all pointers and counts 0, Output=0, Valid=0, Empty=all 1, Full=all 0, Overflow=all 0; FIFO storage contents unspecified.
- Reset mid-operation: all buffered data discarded immediately; first rising edge after Rst deasserts may push/pop normally.
- Write latency: entry visible (Empty falls) one cycle after the strobe edge.
- Read latency: Output and Valid update on the edge that samples Read; Output holds until the next successful pop.
- Full/Empty reflect the state after the previous edge; the bench checks them before strobing.
- Throughput: one push per channel and one pop total per cycle.

## Structure
- Package input_port_pkg: default WIDTH/DEPTH/CHANNELS constants, and the function that derives the select width.
- Sub-module input_port_chan: one channel FIFO (storage, pointers, count, Overflow, Empty/Full), instantiated CHANNELS times in a generate loop.
- The top level holds the Sel decode, the output mux, and the Output/Valid registers.

## Test plan
- Reset: drive Rst low mid-stream with 3 entries queued → Output=0, Empty=2'b11, Full=0, Overflow=0 immediately; the next Read gives Valid=0.
- Fill and drain ch0: write 0x11,0x22,0x33,0x44 → Full[0]=1; read 4 times → Output 0x11,0x22,0x33,0x44 with Valid each cycle; then Empty[0]=1.
- Overflow: with ch1 full, write 0x55 → Overflow[1]=1 and the data is dropped, so the reads return the original 4 entries. ClearOvf with Sel=1 → 0. ClearOvf together with another dropped write → stays 1.
- Full + simultaneous read/write on ch0: entries 0xA0..0xA3 queued, Read and write 0xA4 together → Output=0xA0, Full stays 1, no overflow; the following reads give 0xA1..0xA4.
- Empty + simultaneous read/write: Read and write 0x7E together on an empty channel → Valid=0, Output unchanged; next Read → 0x7E.
- Channel independence and wrap: interleave writes to ch0/ch1 while reading ch1 for 3×DEPTH entries → each channel returns its own data in order across pointer wrap.
